// File: rtl/iq_pkg.sv
// iq_pkg: shared defaults and entry record for the issue queue.
package iq_pkg;
  localparam int IQ_ENTRIES = 8;
  localparam int IQ_TAG_W   = 6;
  localparam int IQ_PAY_W   = 32;
  typedef struct packed {
    logic                valid;
    logic [IQ_TAG_W-1:0] src0_tag;
    logic                src0_rdy;
    logic [IQ_TAG_W-1:0] src1_tag;
    logic                src1_rdy;
    logic [IQ_TAG_W-1:0] dst_tag;
    logic [IQ_PAY_W-1:0] payload;
  } iq_entry_t;
endpackage

// File: rtl/iq_alloc_pick.sv
// iq_alloc_pick: lowest-index one-hot pick over free slots plus any-free flag.
module iq_alloc_pick #(
  parameter int N = 8
) (
  input  logic [N-1:0] free,
  output logic [N-1:0] pick,
  output logic         any
);
  assign pick = free & (~free + N'(1));
  assign any  = |free;
endmodule

// File: rtl/issue_queue_client.sv
// issue_queue_client: wakeup/select issue queue with registered single issue.
module issue_queue_client
  import iq_pkg::*;
#(
  parameter int ENTRIES = IQ_ENTRIES,
  parameter int TAG_W   = IQ_TAG_W,
  parameter int PAY_W   = IQ_PAY_W
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               flush_i,
  input  logic               disp_valid_i,
  output logic               disp_ready_o,
  input  logic [TAG_W-1:0]   disp_src0_tag_i,
  input  logic [TAG_W-1:0]   disp_src1_tag_i,
  input  logic               disp_src0_rdy_i,
  input  logic               disp_src1_rdy_i,
  input  logic [TAG_W-1:0]   disp_dst_tag_i,
  input  logic [PAY_W-1:0]   disp_pay_i,
  input  logic               wb_valid_i,
  input  logic [TAG_W-1:0]   wb_tag_i,
  output logic [ENTRIES-1:0] req_o,
  input  logic [ENTRIES-1:0] grant_i,
  output logic               iss_valid_o,
  output logic [TAG_W-1:0]   iss_dst_tag_o,
  output logic [PAY_W-1:0]   iss_pay_o,
  output logic               grant_err_o
);
  iq_entry_t          ent [ENTRIES];
  iq_entry_t          sel;
  logic [ENTRIES-1:0] valid, req_v, alloc_oh, honoured, gnt_oh;
  logic               disp_fire, grant_bad;
  always_comb begin
    valid = '0;
    req_v = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      valid[i] = ent[i].valid;
      req_v[i] = ent[i].valid & ent[i].src0_rdy & ent[i].src1_rdy;
    end
  end
  iq_alloc_pick #(.N(ENTRIES)) u_pick (
    .free (~valid),
    .pick (alloc_oh),
    .any  (disp_ready_o)
  );
  assign req_o     = req_v;
  assign disp_fire = disp_valid_i & disp_ready_o;
  assign honoured  = grant_i & req_v;
  assign gnt_oh    = honoured & (~honoured + ENTRIES'(1));
  assign grant_bad = (|(grant_i & ~req_v)) | (|(grant_i & (grant_i - ENTRIES'(1))));
  always_comb begin
    sel = '0;
    for (int i = 0; i < ENTRIES; i++)
      sel = gnt_oh[i] ? ent[i] : sel;
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < ENTRIES; i++) ent[i] <= '0;
      iss_valid_o   <= 1'b0;
      iss_dst_tag_o <= '0;
      iss_pay_o     <= '0;
      grant_err_o   <= 1'b0;
    end else begin
      grant_err_o <= grant_err_o | grant_bad;
      iss_valid_o <= !flush_i && (|gnt_oh);
      if (!flush_i && (|gnt_oh)) begin
        iss_dst_tag_o <= sel.dst_tag;
        iss_pay_o     <= sel.payload;
      end
      for (int i = 0; i < ENTRIES; i++) begin
        if (flush_i) ent[i].valid <= 1'b0;
        else begin
          if (wb_valid_i && ent[i].valid && ent[i].src0_tag == wb_tag_i) ent[i].src0_rdy <= 1'b1;
          if (wb_valid_i && ent[i].valid && ent[i].src1_tag == wb_tag_i) ent[i].src1_rdy <= 1'b1;
          if (gnt_oh[i]) ent[i].valid <= 1'b0;
          // a freshly dispatched source can be woken by the broadcast it races with
          if (disp_fire && alloc_oh[i])
            ent[i] <= '{valid:    1'b1,
                        src0_tag: disp_src0_tag_i,
                        src0_rdy: disp_src0_rdy_i | (wb_valid_i && disp_src0_tag_i == wb_tag_i),
                        src1_tag: disp_src1_tag_i,
                        src1_rdy: disp_src1_rdy_i | (wb_valid_i && disp_src1_tag_i == wb_tag_i),
                        dst_tag:  disp_dst_tag_i,
                        payload:  disp_pay_i};
        end
      end
    end
  end
endmodule

// File: tb/tb_issue_queue_client.sv
// tb_issue_queue_client: scenario tasks with a scoreboard of expected issues.
module tb_issue_queue_client;
  logic        clk = 0;
  logic        rst = 1;
  logic        flush = 0;
  logic        disp_valid = 0;
  logic        disp_ready;
  logic [5:0]  s0_tag = 0, s1_tag = 0, dst_tag = 0, wb_tag = 0;
  logic        s0_rdy = 0, s1_rdy = 0, wb_valid = 0;
  logic [31:0] pay = 0;
  logic [7:0]  req, grant = 0;
  logic        iss_valid, grant_err;
  logic [5:0]  iss_dst;
  logic [31:0] iss_pay;
  int errs = 0;
  int checks = 0;
  typedef struct packed {logic [5:0] dst; logic [31:0] pay;} iss_t;
  iss_t sb[$];
  iss_t exp_i;

  issue_queue_client dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .disp_valid_i(disp_valid), .disp_ready_o(disp_ready),
    .disp_src0_tag_i(s0_tag), .disp_src1_tag_i(s1_tag),
    .disp_src0_rdy_i(s0_rdy), .disp_src1_rdy_i(s1_rdy),
    .disp_dst_tag_i(dst_tag), .disp_pay_i(pay),
    .wb_valid_i(wb_valid), .wb_tag_i(wb_tag),
    .req_o(req), .grant_i(grant),
    .iss_valid_o(iss_valid), .iss_dst_tag_o(iss_dst), .iss_pay_o(iss_pay),
    .grant_err_o(grant_err)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_disp(input logic v, input logic [5:0] t0, input logic r0,
                          input logic [5:0] t1, input logic r1,
                          input logic [5:0] d, input logic [31:0] p);
    disp_valid = v; s0_tag = t0; s0_rdy = r0; s1_tag = t1; s1_rdy = r1; dst_tag = d; pay = p;
  endtask

  task automatic test_reset;
    rst = 1;
    tick();
    checks++;
    if (req !== 8'h00 || iss_valid !== 1'b0 || grant_err !== 1'b0 || iss_dst !== 6'd0 || iss_pay !== 32'd0) begin
      errs++;
      $display("FAIL reset_state req=%h iss_valid=%b err=%b dst=%h pay=%h want 00/0/0/0/0", req, iss_valid, grant_err, iss_dst, iss_pay);
    end
    rst = 0;
    tick();
    checks++;
    if (disp_ready !== 1'b1) begin errs++; $display("FAIL reset_ready got %b want 1", disp_ready); end
  endtask

  task automatic test_fill_drain;
    for (int i = 0; i < 8; i++) begin
      set_disp(1, 6'd1, 1, 6'd2, 1, 6'(i), 32'hA000 + i);
      tick();
    end
    checks++;
    if (disp_ready !== 1'b0 || req !== 8'hFF) begin
      errs++; $display("FAIL fill_full ready=%b req=%h want 0/ff", disp_ready, req);
    end
    set_disp(1, 6'd1, 1, 6'd2, 1, 6'd63, 32'hDEAD);
    tick();
    set_disp(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      grant = 8'(1 << i);
      sb.push_back('{dst: 6'(i), pay: 32'hA000 + i});
      tick();
      grant = 0;
      exp_i = sb.pop_front();
      checks++;
      if (iss_valid !== 1'b1 || iss_dst !== exp_i.dst || iss_pay !== exp_i.pay || req[i] !== 1'b0) begin
        errs++; $display("FAIL drain_issue%0d v=%b dst=%h pay=%h req=%h want 1/%h/%h", i, iss_valid, iss_dst, iss_pay, req, exp_i.dst, exp_i.pay);
      end
    end
    tick();
    checks++;
    if (iss_valid !== 1'b0 || iss_dst !== 6'd7 || iss_pay !== 32'hA007 || req !== 8'h00 || grant_err !== 1'b0) begin
      errs++; $display("FAIL drain_idle v=%b dst=%h pay=%h req=%h err=%b want 0/07/a007/00/0", iss_valid, iss_dst, iss_pay, req, grant_err);
    end
  endtask

  task automatic test_wakeup;
    set_disp(1, 6'd5, 0, 6'd1, 1, 6'd11, 32'h55);
    tick();
    set_disp(0, 0, 0, 0, 0, 0, 0);
    wb_valid = 1; wb_tag = 6'd7;
    tick();
    checks++;
    if (req[0] !== 1'b0) begin errs++; $display("FAIL wake_wrong_tag req=%h want bit0=0", req); end
    wb_tag = 6'd5;
    tick();
    wb_valid = 0;
    checks++;
    if (req[0] !== 1'b1) begin errs++; $display("FAIL wake_match req=%h want bit0=1", req); end
    grant = 8'h01;
    sb.push_back('{dst: 6'd11, pay: 32'h55});
    tick();
    grant = 0;
    exp_i = sb.pop_front();
    checks++;
    if (iss_valid !== 1'b1 || iss_dst !== exp_i.dst || iss_pay !== exp_i.pay) begin
      errs++; $display("FAIL wake_issue v=%b dst=%h pay=%h want 1/%h/%h", iss_valid, iss_dst, iss_pay, exp_i.dst, exp_i.pay);
    end
  endtask

  task automatic test_same_cycle_wakeup;
    set_disp(1, 6'd9, 0, 6'd3, 1, 6'd12, 32'h99);
    wb_valid = 1; wb_tag = 6'd9;
    tick();
    set_disp(0, 0, 0, 0, 0, 0, 0);
    wb_valid = 0;
    checks++;
    if (req !== 8'h01) begin errs++; $display("FAIL same_cycle_wake req=%h want 01", req); end
    grant = 8'h01;
    tick();
    grant = 0;
  endtask

  task automatic test_grant;
    for (int i = 0; i < 3; i++) begin
      set_disp(1, 0, 1, 0, 1, 6'(20 + i), 32'hB000 + i);
      tick();
    end
    set_disp(0, 0, 0, 0, 0, 0, 0);
    grant = 8'h04;
    sb.push_back('{dst: 6'd22, pay: 32'hB002});
    tick();
    grant = 0;
    exp_i = sb.pop_front();
    checks++;
    if (iss_valid !== 1'b1 || iss_dst !== exp_i.dst || iss_pay !== exp_i.pay || req !== 8'h03 || grant_err !== 1'b0) begin
      errs++; $display("FAIL grant_one v=%b dst=%h pay=%h req=%h err=%b want 1/%h/%h/03/0", iss_valid, iss_dst, iss_pay, req, grant_err, exp_i.dst, exp_i.pay);
    end
    grant = 8'h03;
    tick();
    grant = 0;
    checks++;
    if (grant_err !== 1'b1 || req !== 8'h02 || iss_dst !== 6'd20) begin
      errs++; $display("FAIL grant_pair err=%b req=%h dst=%h want 1/02/14", grant_err, req, iss_dst);
    end
    rst = 1;
    tick();
    rst = 0;
    tick();
  endtask

  task automatic test_multi_grant;
    set_disp(1, 6'd30, 0, 0, 1, 6'd40, 32'hC000);
    tick();
    set_disp(1, 0, 1, 0, 1, 6'd41, 32'hC001);
    tick();
    set_disp(1, 0, 1, 0, 1, 6'd42, 32'hC002);
    tick();
    set_disp(0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (req !== 8'h06 || grant_err !== 1'b0) begin errs++; $display("FAIL multi_setup req=%h err=%b want 06/0", req, grant_err); end
    grant = 8'h06;
    sb.push_back('{dst: 6'd41, pay: 32'hC001});
    tick();
    grant = 0;
    exp_i = sb.pop_front();
    checks++;
    if (iss_valid !== 1'b1 || iss_dst !== exp_i.dst || iss_pay !== exp_i.pay || req !== 8'h04 || grant_err !== 1'b1) begin
      errs++; $display("FAIL multi_grant v=%b dst=%h pay=%h req=%h err=%b want 1/%h/%h/04/1", iss_valid, iss_dst, iss_pay, req, grant_err, exp_i.dst, exp_i.pay);
    end
    rst = 1;
    tick();
    rst = 0;
    set_disp(1, 0, 1, 0, 1, 6'd43, 32'hC003);
    tick();
    set_disp(0, 0, 0, 0, 0, 0, 0);
    grant = 8'h80;
    tick();
    grant = 0;
    checks++;
    if (iss_valid !== 1'b0 || req !== 8'h01 || grant_err !== 1'b1) begin
      errs++; $display("FAIL stray_grant v=%b req=%h err=%b want 0/01/1", iss_valid, req, grant_err);
    end
  endtask

  task automatic test_flush;
    flush = 1;
    tick();
    flush = 0;
    for (int i = 0; i < 8; i++) begin
      set_disp(1, 0, 1, 0, 1, 6'(i), 32'hD000 + i);
      tick();
    end
    flush = 1; grant = 8'h01;
    tick();
    flush = 0; grant = 0;
    set_disp(0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (req !== 8'h00 || iss_valid !== 1'b0 || disp_ready !== 1'b1 || grant_err !== 1'b1) begin
      errs++; $display("FAIL flush req=%h v=%b ready=%b err=%b want 00/0/1/1", req, iss_valid, disp_ready, grant_err);
    end
  endtask

  task automatic test_back_to_back;
    logic [5:0] model_dst [8];
    rst = 1;
    tick();
    rst = 0;
    checks++;
    if (grant_err !== 1'b0) begin errs++; $display("FAIL err_cleared got %b want 0", grant_err); end
    for (int i = 0; i < 8; i++) begin
      set_disp(1, 0, 1, 0, 1, 6'(i + 32), 32'hE000 + i);
      model_dst[i] = 6'(i + 32);
      tick();
    end
    grant = 8'h08;
    set_disp(1, 0, 1, 0, 1, 6'd50, 32'hE050);
    tick();
    grant = 0;
    checks++;
    if (disp_ready !== 1'b1 || req !== 8'hF7 || iss_dst !== 6'd35) begin
      errs++; $display("FAIL no_realloc ready=%b req=%h dst=%h want 1/f7/23", disp_ready, req, iss_dst);
    end
    model_dst[3] = 6'd50;
    tick();
    set_disp(0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (req !== 8'hFF) begin errs++; $display("FAIL realloc req=%h want ff", req); end
    for (int i = 0; i < 8; i++) begin
      grant = 8'(1 << i);
      sb.push_back('{dst: model_dst[i], pay: (i == 3) ? 32'hE050 : 32'hE000 + i});
      tick();
      exp_i = sb.pop_front();
      checks++;
      if (iss_valid !== 1'b1 || iss_dst !== exp_i.dst || iss_pay !== exp_i.pay) begin
        errs++; $display("FAIL b2b_issue%0d v=%b dst=%h pay=%h want 1/%h/%h", i, iss_valid, iss_dst, iss_pay, exp_i.dst, exp_i.pay);
      end
    end
    grant = 0;
  endtask

  task automatic test_async_reset;
    set_disp(1, 0, 1, 0, 1, 6'd7, 32'h77);
    tick();
    grant = 8'h01;
    set_disp(1, 0, 1, 0, 1, 6'd8, 32'h88);
    #2 rst = 1;
    #1;
    checks++;
    if (req !== 8'h00 || iss_valid !== 1'b0 || disp_ready !== 1'b1) begin
      errs++; $display("FAIL async_reset req=%h v=%b ready=%b want 00/0/1", req, iss_valid, disp_ready);
    end
    tick();
    rst = 0; grant = 0;
    set_disp(0, 0, 0, 0, 0, 0, 0);
    tick();
    checks++;
    if (req !== 8'h00 || iss_valid !== 1'b0 || iss_dst !== 6'd0) begin
      errs++; $display("FAIL reset_discard req=%h v=%b dst=%h want 00/0/00", req, iss_valid, iss_dst);
    end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_wakeup();
    test_same_cycle_wakeup();
    test_grant();
    test_multi_grant();
    test_flush();
    test_back_to_back();
    test_async_reset();
    checks++;
    if (sb.size() != 0) begin errs++; $display("FAIL scoreboard_left got %0d want 0", sb.size()); end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
